// File: rtl/n64_joybus_pkg.sv
// Shared definitions for the N64 Joybus controller-emulation datapath:
// command codes, payload lengths and the sequencer state encoding.
package n64_joybus_pkg;

    localparam logic [7:0] CMD_INFO   = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_WRITE  = 8'h03;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam int unsigned LEN_W = 6;
    localparam logic [LEN_W-1:0] LEN_NONE  = 6'd0;
    localparam logic [LEN_W-1:0] LEN_READ  = 6'd2;
    localparam logic [LEN_W-1:0] LEN_WRITE = 6'd34;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StTurnaround,
        StTxActive,
        StRecover
    } seq_state_e;

    function automatic logic cmd_known(input logic [7:0] code);
        case (code)
            CMD_INFO, CMD_STATUS, CMD_READ, CMD_WRITE, CMD_RESET: cmd_known = 1'b1;
            default:                                              cmd_known = 1'b0;
        endcase
    endfunction

    function automatic logic [LEN_W-1:0] payload_len(input logic [7:0] code);
        case (code)
            CMD_READ:  payload_len = LEN_READ;
            CMD_WRITE: payload_len = LEN_WRITE;
            default:   payload_len = LEN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/n64_seq_watchdog.sv
// TX watchdog: counts enabled cycles since the last clear and pulses expired
// for one cycle when the count reaches TIMEOUT_CYCLES; the count then saturates.
module n64_seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 2048,
    parameter int unsigned CNT_W          = 12
) (
    input  logic sample_clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (clear) begin
                cnt_q <= '0;
            end else if (enable && cnt_q != LIMIT) begin
                cnt_q   <= cnt_q + CNT_W'(1);
                expired <= (cnt_q + CNT_W'(1)) == LIMIT;
            end
        end
    end

endmodule

// File: rtl/n64_joybus_sequencer.sv
// Half-duplex Joybus line-direction controller between the RX path and TX.
// Define N64_SEQ_TIMEOUT_EN to add the TX watchdog and the RECOVER state.
module n64_joybus_sequencer
    import n64_joybus_pkg::*;
#(
    parameter int unsigned TURNAROUND_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES    = 2048,
    parameter int unsigned CNT_W             = 12
) (
    input  logic        sample_clk,
    input  logic        reset,
    input  logic        rx_cmd_valid,
    input  logic [7:0]  rx_cmd,
    input  logic        rx_byte_valid,
    input  logic [7:0]  rx_payload_crc,
    input  logic [15:0] button_state_in,
    input  logic [15:0] stick_state_in,
    input  logic        rx_handoff,
    output logic        cur_operation,
    output logic [7:0]  cmd,
    output logic [7:0]  crc,
    output logic [15:0] button_state,
    output logic [15:0] stick_state,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURNAROUND_CYCLES - 1);

    if (TURNAROUND_CYCLES < 1 || CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_param_check
        $error("n64_joybus_sequencer: bad TURNAROUND_CYCLES/CNT_W");
    end

    seq_state_e       state_q;
    logic [CNT_W-1:0] turn_cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] byte_cnt_q;
    logic             handoff_q;
    logic             handoff_change;
    logic             wd_expired;

    // TX signals completion by toggling, so any edge relative to history counts.
    assign handoff_change = rx_handoff ^ handoff_q;
    assign busy           = (state_q != StIdle);

`ifdef N64_SEQ_TIMEOUT_EN
    n64_seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .sample_clk (sample_clk),
        .reset      (reset),
        .clear      (state_q != StTxActive),
        .enable     (state_q == StTxActive),
        .expired    (wd_expired)
    );
    assign timeout_err = wd_expired;
`else
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cur_operation <= 1'b0;
            cmd           <= 8'h00;
            crc           <= 8'h00;
            button_state  <= 16'h0000;
            stick_state   <= 16'h0000;
            handoff_q     <= 1'b0;
            turn_cnt_q    <= '0;
            len_q         <= '0;
            byte_cnt_q    <= '0;
        end else begin
            handoff_q <= rx_handoff;
            case (state_q)
                // A new command in COLLECT restarts the transaction and wins over a byte.
                StIdle, StCollect: begin
                    if (rx_cmd_valid) begin
                        if (cmd_known(rx_cmd)) begin
                            cmd        <= rx_cmd;
                            len_q      <= payload_len(rx_cmd);
                            byte_cnt_q <= '0;
                            if (payload_len(rx_cmd) == LEN_NONE) begin
                                button_state <= button_state_in;
                                stick_state  <= stick_state_in;
                                turn_cnt_q   <= '0;
                                state_q      <= StTurnaround;
                            end else begin
                                state_q <= StCollect;
                            end
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (state_q == StCollect && rx_byte_valid) begin
                        if (byte_cnt_q == len_q - LEN_W'(1)) begin
                            crc          <= rx_payload_crc;
                            button_state <= button_state_in;
                            stick_state  <= stick_state_in;
                            turn_cnt_q   <= '0;
                            state_q      <= StTurnaround;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + LEN_W'(1);
                        end
                    end
                end
                StTurnaround: begin
                    if (turn_cnt_q == TURN_LAST) begin
                        cur_operation <= 1'b1;
                        state_q       <= StTxActive;
                    end else begin
                        turn_cnt_q <= turn_cnt_q + CNT_W'(1);
                    end
                end
                StTxActive: begin
                    if (handoff_change) begin
                        cur_operation <= 1'b0;
                        state_q       <= StIdle;
                    end else if (wd_expired) begin
                        cur_operation <= 1'b0;
                        turn_cnt_q    <= '0;
                        state_q       <= StRecover;
                    end
                end
`ifdef N64_SEQ_TIMEOUT_EN
                StRecover: begin
                    if (turn_cnt_q == TURN_LAST) begin
                        state_q <= StIdle;
                    end else begin
                        turn_cnt_q <= turn_cnt_q + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    cur_operation <= 1'b0;
                    state_q       <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n64_joybus_sequencer.sv
// Directed self-checking bench for n64_joybus_sequencer (TURNAROUND 4, TIMEOUT 16).
module tb_n64_joybus_sequencer;

    localparam int TURN = 4;
    localparam int TMO  = 16;

    logic        sample_clk = 1'b0;
    logic        reset;
    logic        rx_cmd_valid;
    logic [7:0]  rx_cmd;
    logic        rx_byte_valid;
    logic [7:0]  rx_payload_crc;
    logic [15:0] button_state_in;
    logic [15:0] stick_state_in;
    logic        rx_handoff;
    logic        cur_operation;
    logic [7:0]  cmd;
    logic [7:0]  crc;
    logic [15:0] button_state;
    logic [15:0] stick_state;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 sample_clk = ~sample_clk;

    n64_joybus_sequencer #(
        .TURNAROUND_CYCLES (TURN),
        .TIMEOUT_CYCLES    (TMO),
        .CNT_W             (12)
    ) dut (
        .sample_clk      (sample_clk),
        .reset           (reset),
        .rx_cmd_valid    (rx_cmd_valid),
        .rx_cmd          (rx_cmd),
        .rx_byte_valid   (rx_byte_valid),
        .rx_payload_crc  (rx_payload_crc),
        .button_state_in (button_state_in),
        .stick_state_in  (stick_state_in),
        .rx_handoff      (rx_handoff),
        .cur_operation   (cur_operation),
        .cmd             (cmd),
        .crc             (crc),
        .button_state    (button_state),
        .stick_state     (stick_state),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    // Returns at the negedge following the sampling posedge.
    task automatic send_cmd(input logic [7:0] c);
        rx_cmd       = c;
        rx_cmd_valid = 1'b1;
        @(negedge sample_clk);
        rx_cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] crc_v);
        rx_payload_crc = crc_v;
        rx_byte_valid  = 1'b1;
        @(negedge sample_clk);
        rx_byte_valid  = 1'b0;
    endtask

    // n = negedges since the sampling edge (first one after it is 1); bounded.
    task automatic wait_grant(input int start, output int n);
        n = start;
        while (!cur_operation && n < 64) begin
            @(negedge sample_clk);
            n++;
        end
    endtask

    task automatic toggle_handoff();
        rx_handoff = ~rx_handoff;
        @(negedge sample_clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if ({cur_operation, busy, timeout_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {cur_operation, busy, timeout_err});
        end
        checks++;
        if ({cmd, crc, button_state, stick_state} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {cmd, crc, button_state, stick_state});
        end
        @(negedge sample_clk);
        @(negedge sample_clk);
        reset = 1'b0;
        @(negedge sample_clk);
    endtask

    task automatic test_status();
        int n;
        button_state_in = 16'hA5C3;
        stick_state_in  = 16'h0F0F;
        send_cmd(8'h01);
        wait_grant(1, n);
        checks++;
        if (n !== TURN + 1) begin
            errors++;
            $display("FAIL status_grant_latency: got %0d expected %0d", n, TURN + 1);
        end
        button_state_in = 16'h1234;
        stick_state_in  = 16'h5678;
        repeat (3) @(negedge sample_clk);
        checks++;
        if ({button_state, stick_state} !== 32'hA5C3_0F0F) begin
            errors++;
            $display("FAIL status_snapshot_hold: got %h expected a5c30f0f",
                     {button_state, stick_state});
        end
        checks++;
        if ({cmd, cur_operation, busy} !== {8'h01, 2'b11}) begin
            errors++;
            $display("FAIL status_tx_state: got %h/%b%b expected 01/11", cmd, cur_operation, busy);
        end
        toggle_handoff();
        checks++;
        if ({cur_operation, busy} !== 2'b00) begin
            errors++;
            $display("FAIL status_handoff_release: got %b expected 00", {cur_operation, busy});
        end
    endtask

    task automatic test_write();
        int n;
        send_cmd(8'h03);
        for (int i = 0; i < 33; i++) begin
            send_byte(8'(i));
            @(negedge sample_clk);
        end
        repeat (8) @(negedge sample_clk);
        checks++;
        if ({cur_operation, busy} !== 2'b01) begin
            errors++;
            $display("FAIL write_33_no_grant: got %b expected 01", {cur_operation, busy});
        end
        button_state_in = 16'hBEEF;
        send_byte(8'h3C);
        wait_grant(1, n);
        checks++;
        if (n !== TURN + 1) begin
            errors++;
            $display("FAIL write_grant_latency: got %0d expected %0d", n, TURN + 1);
        end
        checks++;
        if ({cmd, crc, button_state} !== 32'h03_3C_BEEF) begin
            errors++;
            $display("FAIL write_latched: got %h expected 033cbeef", {cmd, crc, button_state});
        end
        toggle_handoff();
    endtask

    task automatic test_unknown();
        logic seen = 1'b0;
        send_cmd(8'h7E);
        repeat (10) begin
            seen |= busy | cur_operation;
            @(negedge sample_clk);
        end
        checks++;
        if ({seen, cmd} !== {1'b0, 8'h03}) begin
            errors++;
            $display("FAIL unknown_ignored: got %b/%h expected 0/03", seen, cmd);
        end
    endtask

    task automatic test_read_abort();
        int n;
        send_cmd(8'h02);
        send_byte(8'h11);
        @(negedge sample_clk);
        checks++;
        if ({cur_operation, busy} !== 2'b01) begin
            errors++;
            $display("FAIL read_collecting: got %b expected 01", {cur_operation, busy});
        end
        send_cmd(8'h00);
        wait_grant(1, n);
        checks++;
        if (n !== TURN + 1 || cmd !== 8'h00) begin
            errors++;
            $display("FAIL read_abort_restart: got %0d/%h expected %0d/00", n, cmd, TURN + 1);
        end
        toggle_handoff();
    endtask

    // Commands arriving during TURNAROUND must not disturb the pending grant.
    task automatic test_ignore_in_turnaround();
        int n;
        send_cmd(8'hFF);
        rx_cmd          = 8'h03;
        rx_cmd_valid    = 1'b1;
        rx_byte_valid   = 1'b1;
        @(negedge sample_clk);
        rx_cmd_valid    = 1'b0;
        rx_byte_valid   = 1'b0;
        wait_grant(2, n);
        checks++;
        if (n !== TURN + 1 || cmd !== 8'hFF) begin
            errors++;
            $display("FAIL ignore_in_turnaround: got %0d/%h expected %0d/ff", n, cmd, TURN + 1);
        end
        toggle_handoff();
    endtask

    task automatic test_watchdog();
        int n;
        send_cmd(8'h01);
        wait_grant(1, n);
        checks++;
        if (n !== TURN + 1) begin
            errors++;
            $display("FAIL wd_grant_latency: got %0d expected %0d", n, TURN + 1);
        end
`ifdef N64_SEQ_TIMEOUT_EN
        begin
            int k = 0;
            int j = 0;
            while (!timeout_err && k < 64) begin
                @(negedge sample_clk);
                k++;
            end
            checks++;
            if (k !== TMO) begin
                errors++;
                $display("FAIL wd_timeout_delay: got %0d expected %0d", k, TMO);
            end
            @(negedge sample_clk);
            checks++;
            if ({timeout_err, cur_operation, busy} !== 3'b001) begin
                errors++;
                $display("FAIL wd_recover_entry: got %b expected 001",
                         {timeout_err, cur_operation, busy});
            end
            while (busy && j < 64) begin
                @(negedge sample_clk);
                j++;
            end
            checks++;
            if (j !== TURN) begin
                errors++;
                $display("FAIL wd_recover_len: got %0d expected %0d", j, TURN);
            end
        end
`else
        begin
            logic seen = 1'b0;
            repeat (40) begin
                seen |= timeout_err;
                @(negedge sample_clk);
            end
            checks++;
            if ({seen, cur_operation} !== 2'b01) begin
                errors++;
                $display("FAIL wd_disabled_hold: got %b expected 01", {seen, cur_operation});
            end
            toggle_handoff();
            checks++;
            if (cur_operation !== 1'b0) begin
                errors++;
                $display("FAIL wd_disabled_release: got %b expected 0", cur_operation);
            end
        end
`endif
    endtask

    task automatic test_reset_in_tx();
        int n;
        send_cmd(8'hFF);
        wait_grant(1, n);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({cur_operation, busy, cmd, button_state} !== 26'h0) begin
            errors++;
            $display("FAIL reset_in_tx_async: got %b%b/%h/%h expected 00/00/0000",
                     cur_operation, busy, cmd, button_state);
        end
        @(negedge sample_clk);
        reset = 1'b0;
        @(negedge sample_clk);
    endtask

    task automatic test_stray_handoff();
        int n;
        toggle_handoff();
        repeat (5) @(negedge sample_clk);
        checks++;
        if ({cur_operation, busy} !== 2'b00) begin
            errors++;
            $display("FAIL stray_handoff_idle: got %b expected 00", {cur_operation, busy});
        end
        send_cmd(8'h01);
        wait_grant(1, n);
        repeat (3) @(negedge sample_clk);
        checks++;
        if (n !== TURN + 1 || cur_operation !== 1'b1) begin
            errors++;
            $display("FAIL stray_handoff_grant: got %0d/%b expected %0d/1", n, cur_operation,
                     TURN + 1);
        end
        toggle_handoff();
        checks++;
        if (cur_operation !== 1'b0) begin
            errors++;
            $display("FAIL stray_handoff_release: got %b expected 0", cur_operation);
        end
    endtask

    initial begin
        reset           = 1'b1;
        rx_cmd_valid    = 1'b0;
        rx_cmd          = 8'h00;
        rx_byte_valid   = 1'b0;
        rx_payload_crc  = 8'h00;
        button_state_in = 16'h0000;
        stick_state_in  = 16'h0000;
        rx_handoff      = 1'b0;
        test_reset();
        test_status();
        test_write();
        test_unknown();
        test_read_abort();
        test_ignore_in_turnaround();
        test_watchdog();
        test_reset_in_tx();
        test_stray_handoff();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
